fetch_unit: RTL

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit_pkg.sv | 21 ++
 rtl/fetch_unit.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/fetch_unit_pkg.sv
// Shared constants for the instruction fetch unit: reset PC default,
// the NOP encoding presented while no instruction has been fetched,
// FSM state encodings, and a small PC alignment helper.
package fetch_unit_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
  localparam logic [31:0] PC_STEP          = 32'h0000_0004;

  // FSM state encodings (legacy-compatible plain constants)
  localparam logic [1:0] S_REQ  = 2'd0;  // presenting a request to imem
  localparam logic [1:0] S_WAIT = 2'd1;  // request accepted, awaiting rvalid
  localparam logic [1:0] S_DROP = 2'd2;  // flushed request still in flight
  localparam logic [1:0] S_HOLD = 2'd3;  // instruction presented to decode

  // Force an address onto a 32-bit word boundary.
  function automatic logic [31:0] word_align(input logic [31:0] addr);
    word_align = addr & 32'hFFFF_FFFC;
  endfunction

endpackage

// File: rtl/fetch_unit.sv
// Single-outstanding-request instruction fetch unit. A four-state FSM
// issues one imem request at a time, presents the returned instruction
// to decode until it is consumed, and flushes in-flight work on redirect.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        stall,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        if_valid,
  output logic [31:0] if_pc,
  output logic [31:0] if_instr,
  output logic        misalign_err
);

  logic [1:0]  state_r;
  logic [31:0] pc_r;
  logic        if_valid_r;
  logic [31:0] if_pc_r;
  logic [31:0] if_instr_r;
  logic        misalign_r;

  logic [1:0]  state_nxt_s;
  logic [31:0] pc_nxt_s;
  logic        if_valid_nxt_s;
  logic [31:0] if_pc_nxt_s;
  logic [31:0] if_instr_nxt_s;
  logic        misalign_nxt_s;
  logic [31:0] redirect_tgt_s;

  // Request outputs decode from registered state only, so no input reaches them combinationally.
  always_comb begin
    imem_req  = (state_r == S_REQ);
    imem_addr = pc_r;
  end

  assign if_valid     = if_valid_r;
  assign if_pc        = if_pc_r;
  assign if_instr     = if_instr_r;
  assign misalign_err = misalign_r;

  // Next-state logic; redirect is examined first in every state so it wins over all other inputs.
  always_comb begin
    state_nxt_s    = state_r;
    pc_nxt_s       = pc_r;
    if_valid_nxt_s = if_valid_r;
    if_pc_nxt_s    = if_pc_r;
    if_instr_nxt_s = if_instr_r;
    redirect_tgt_s = word_align(redirect_pc);
    misalign_nxt_s = redirect_valid & (redirect_pc[1:0] != 2'b00);

    case (state_r)
      S_REQ: begin
        if (redirect_valid) begin
          pc_nxt_s = redirect_tgt_s;
          // A handshake in the same cycle still launched a request whose data must be dropped.
          if (imem_ready) begin
            state_nxt_s = S_DROP;
          end else begin
            state_nxt_s = S_REQ;
          end
        end else if (imem_ready) begin
          state_nxt_s = S_WAIT;
        end else begin
          state_nxt_s = S_REQ;
        end
      end

      S_WAIT: begin
        if (redirect_valid) begin
          pc_nxt_s = redirect_tgt_s;
          // If the stale response arrives this very cycle nothing is left in flight.
          if (imem_rvalid) begin
            state_nxt_s = S_REQ;
          end else begin
            state_nxt_s = S_DROP;
          end
        end else if (imem_rvalid) begin
          if_instr_nxt_s = imem_rdata;
          if_pc_nxt_s    = pc_r;
          if_valid_nxt_s = 1'b1;
          pc_nxt_s       = pc_r + PC_STEP;  // wraps modulo 2^32 by width
          state_nxt_s    = S_HOLD;
        end else begin
          state_nxt_s = S_WAIT;
        end
      end

      S_HOLD: begin
        if (redirect_valid) begin
          if_valid_nxt_s = 1'b0;
          pc_nxt_s       = redirect_tgt_s;
          state_nxt_s    = S_REQ;
        end else if (!stall) begin
          if_valid_nxt_s = 1'b0;
          state_nxt_s    = S_REQ;
        end else begin
          state_nxt_s = S_HOLD;
        end
      end

      S_DROP: begin
        if (redirect_valid) begin
          pc_nxt_s = redirect_tgt_s;
        end else begin
          pc_nxt_s = pc_r;
        end
        if (imem_rvalid) begin
          state_nxt_s = S_REQ;
        end else begin
          state_nxt_s = S_DROP;
        end
      end

      default: begin
        if_valid_nxt_s = 1'b0;
        state_nxt_s    = S_REQ;
      end
    endcase
  end

  // State, PC and registered outputs; reset abandons any transaction in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r    <= S_REQ;
      pc_r       <= RESET_PC;
      if_valid_r <= 1'b0;
      if_pc_r    <= 32'h0000_0000;
      if_instr_r <= NOP_INSTR;
      misalign_r <= 1'b0;
    end else begin
      state_r    <= state_nxt_s;
      pc_r       <= pc_nxt_s;
      if_valid_r <= if_valid_nxt_s;
      if_pc_r    <= if_pc_nxt_s;
      if_instr_r <= if_instr_nxt_s;
      misalign_r <= misalign_nxt_s;
    end
  end

endmodule
